// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-access stage. Takes the ALU result as the
// effective address, runs a req/ack handshake to data memory, builds byte
// enables and lane-replicated store data, extends load data, stalls the core
// while an access is in flight and flags misaligned/illegal ops and timeouts.
module load_store_unit #(
   parameter int TIMEOUT_CYC = 16,
   parameter int CNT_W       = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misalign,
   output logic        fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

   // Last REQ cycle in which a missing ack is still tolerated.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_mis_q, err_mis_d;   // ERR cause: 1 = misalign/illegal, 0 = timeout
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic [31:0]       addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;

   // Legal funct3 for the direction, and natural alignment for the size.
   function automatic logic legal_op(input logic we, input logic [2:0] f3, input logic [1:0] o);
      logic ok;
      ok = 1'b0;
      case (f3)
         3'b000:  ok = 1'b1;
         3'b001:  ok = (o[0] == 1'b0);
         3'b010:  ok = (o == 2'b00);
         3'b100:  ok = ~we;
         3'b101:  ok = ~we & (o[0] == 1'b0);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Byte enables from access size (funct3[1:0]) and byte offset.
   function automatic logic [3:0] be_gen(input logic [1:0] sz, input logic [1:0] o);
      logic [3:0] be;
      case (sz)
         2'b00:   be = 4'b0001 << o;
         2'b01:   be = 4'b0011 << o;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Store data replicated across every lane so any offset sees its bytes.
   function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] w);
      logic [31:0] d;
      case (sz)
         2'b00:   d = {4{w[7:0]}};
         2'b01:   d = {2{w[15:0]}};
         default: d = w;
      endcase
      return d;
   endfunction

   // Pick the addressed byte/half lane and sign- or zero-extend it.
   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] o,
                                            input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (o)
         2'b00:   b = rd[7:0];
         2'b01:   b = rd[15:8];
         2'b10:   b = rd[23:16];
         default: b = rd[31:24];
      endcase
      if (o[1]) begin
         h = rd[31:16];
      end else begin
         h = rd[15:0];
      end
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b100:  r = {24'h000000, b};
         3'b101:  r = {16'h0000, h};
         default: r = rd;
      endcase
      return r;
   endfunction

   // Next-state logic: legality check, request capture, ack/timeout handling.
   always_comb begin
      state_d   = state_q;
      cnt_d     = {CNT_W{1'b0}};
      err_mis_d = err_mis_q;
      we_d      = we_q;
      f3_d      = f3_q;
      off_d     = off_q;
      addr_d    = addr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (legal_op(req_we, req_funct3, req_addr[1:0])) begin
                  state_d = REQ;
                  we_d    = req_we;
                  f3_d    = req_funct3;
                  off_d   = req_addr[1:0];
                  addr_d  = {req_addr[31:2], 2'b00};
                  be_d    = be_gen(req_funct3[1:0], req_addr[1:0]);
                  if (req_we) begin
                     wdata_d = store_data(req_funct3[1:0], req_wdata);
                  end else begin
                     wdata_d = 32'h0000_0000;
                  end
               end else begin
                  state_d   = ERR;
                  err_mis_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            // An ack in the expiring cycle still completes the access.
            if (mem_ack) begin
               state_d = DONE;
               if (!we_q) begin
                  rdata_d = load_ext(f3_q, off_q, mem_rdata);
               end else begin
                  rdata_d = rdata_q;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d   = ERR;
               err_mis_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any outstanding access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         err_mis_q <= 1'b0;
         we_q      <= 1'b0;
         f3_q      <= 3'b000;
         off_q     <= 2'b00;
         addr_q    <= 32'h0000_0000;
         be_q      <= 4'b0000;
         wdata_q   <= 32'h0000_0000;
         rdata_q   <= 32'h0000_0000;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_mis_q <= err_mis_d;
         we_q      <= we_d;
         f3_q      <= f3_d;
         off_q     <= off_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
      end
   end

   // Outputs decode registered state; stall also covers the IDLE request cycle.
   assign mem_req   = (state_q == REQ);
   assign done      = (state_q == DONE);
   assign misalign  = (state_q == ERR) & err_mis_q;
   assign fault     = (state_q == ERR) & ~err_mis_q;
   assign stall     = rst_n & (((state_q == IDLE) & req_valid) | (state_q == REQ));
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_be    = be_q;
   assign mem_wdata = wdata_q;
   assign rdata     = rdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU in the RV32I core. It takes the ALU Result as the effective address for LB/LH/LW/LBU/LHU/SB/SH/SW and runs a req/ack handshake to data memory. It generates byte enables and lane-aligned store data, and sign- or zero-extends load data. It stalls the core while an access is outstanding and flags misaligned or illegal accesses and memory timeouts.

Parameters:
TIMEOUT_CYC, 16, cycles spent in REQ without mem_ack before a fault is raised (min 1)
CNT_W, 5, timeout counter width (must hold TIMEOUT_CYC)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  core requests a memory op; held high until done/misalign/fault
req_we  input  1  1=store, 0=load
req_funct3  input  3  RV32I funct3 of the load/store
req_addr  input  32  effective address (ALU Result)
req_wdata  input  32  store data (rs2)
stall  output  1  core must hold PC/operands
done  output  1  one-cycle pulse: access completed
rdata  output  32  extended load result, valid from done onward
misalign  output  1  one-cycle pulse: misaligned address or illegal funct3
fault  output  1  one-cycle pulse: mem_ack timeout
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  memory write enable
mem_addr  output  32  word address {req_addr[31:2],2'b00}
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  memory acceptance/completion, one cycle
mem_rdata  input  32  read data, valid with mem_ack

Behaviour:
- Reset (async, rst_n=0): state=IDLE; stall, done, misalign, fault, mem_req, mem_we = 0; mem_addr, mem_be, mem_wdata, rdata = 0; timeout counter = 0. An outstanding access is abandoned and mem_req drops immediately.
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE, req_valid=0: stay in IDLE; all pulses 0.
- IDLE, req_valid=1: stall=1 combinationally, then legality check:
  - Legal loads: funct3 000, 001, 010, 100, 101.
  - Legal stores: funct3 000, 001, 010.
  - Halfword ops need addr[0]=0; word ops need addr[1:0]=00.
  - Illegal or misaligned -> ERR; no memory request is issued.
  - Legal -> register mem_addr, mem_be, mem_wdata, mem_we, funct3 and addr[1:0]; go to REQ.
- Store data/enables, with o=addr[1:0]:
  - SB: mem_wdata={4{wdata[7:0]}}, mem_be=4'b0001<<o.
  - SH: mem_wdata={2{wdata[15:0]}}, mem_be=4'b0011<<o.
  - SW: mem_wdata=wdata, mem_be=4'b1111.
- Loads: mem_be follows the same rule by size; mem_wdata=0.
- REQ: mem_req=1, stall=1, counter increments each cycle.
  - mem_ack=1 -> go to DONE. For a load, rdata is registered from the byte/half lane selected by offset o.
  - Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Counter reaches TIMEOUT_CYC with no ack -> go to ERR and drop mem_req.
  - mem_ack in the same cycle the timeout expires: the ack wins.
- DONE: done=1 and stall=0 for exactly one cycle; mem_req=0; counter cleared; return to IDLE. The core advances on this edge.
- ERR: stall=0 for one cycle; misalign=1 if entered from IDLE, fault=1 if entered from a timeout; return to IDLE.
- rdata holds its value across stores, errors and idle cycles; only a completed load updates it.
- mem_ack outside REQ is ignored.
- Latency: minimum three cycles from req_valid to done (IDLE, REQ with immediate ack, DONE).
- req_valid dropping while in REQ does not cancel the access; it completes normally.

Test Plan:
- Reset mid-REQ: rst_n low during REQ -> mem_req=0, stall=0, rdata=0, state IDLE immediately.
- LB from addr 0x103, mem_rdata=0x80FF_1234, ack after 2 wait cycles -> mem_addr=0x100, mem_be=0x8, rdata=0xFFFF_FF80, done pulses once, stall high for 4 cycles.
- LHU from addr 0x202, mem_rdata=0xBEEF_0000, immediate ack -> mem_be=0xC, rdata=0x0000_BEEF. Then a SW to 0x300 leaves rdata=0x0000_BEEF.
- SB of wdata=0x1234_56AB to addr 0x401 -> mem_we=1, mem_be=0x2, mem_wdata=0xABAB_ABAB. SH of 0x0000_CAFE to 0x402 -> mem_be=0xC, mem_wdata=0xCAFE_CAFE.
- Misaligned and illegal ops: LW at 0x105, SH at 0x203, and funct3=011 -> misalign pulses for one cycle, no mem_req ever issued, stall=0 in the ERR cycle.
- Timeout with TIMEOUT_CYC=16 and no mem_ack -> mem_req high for exactly 16 cycles, then fault pulses once. Repeat with ack arriving in cycle 16 -> done, no fault.
